cpu_bus_arbiter: RTL and testbench
==================================

# cpu_bus_arbiter

Merges the CPU's instruction bus (cpui_*) and data bus (cpud_*) onto a single pulse-request/ack memory bus (mem_*). It sits directly downstream of the cpu core, between the core and the memory/peripheral fabric. It holds at most one outstanding memory transaction. It arbitrates round-robin when both ports are pending, and it aborts with an error response if memory fails to acknowledge within a bounded time.

## Interface
- TIMEOUT_CYCLES, 255, cycles a memory transaction may wait for mem_ack before it is aborted; legal range ≥2.
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- cpud_request  input  1  data request pulse, one cycle.
- cpud_addr  input  32  data address.
- cpud_write  input  1  1 = write, 0 = read.
- cpud_byte_enable  input  4  write byte lanes.
- cpud_wdata  input  32  write data.
- cpud_rdata  output  32  read data; valid when cpud_ack is high, held afterwards.
- cpud_ack  output  1  data transaction complete, one-cycle pulse.
- cpui_request  input  1  instruction fetch request pulse, one cycle.
- cpui_addr  input  32  fetch address.
- cpui_rdata  output  32  fetched word; valid when cpui_ack is high, held afterwards.
- cpui_ack  output  1  fetch complete, one-cycle pulse.
- mem_request  output  1  memory request pulse, one cycle.
- mem_addr, mem_write, mem_byte_enable, mem_wdata  output  32/1/4/32  request fields; held stable from mem_request until the transaction ends.
- mem_rdata  input  32  memory read data, sampled when mem_ack is high.
- mem_ack  input  1  memory response pulse.
- bus_error  output  1  one-cycle pulse, coincident with the CPU ack of an aborted transaction.

## Operation
**Port capture**
- Each port has a pending flag plus a captured request (addr/write/be/wdata).
- The flag is set on a *_request pulse and cleared when that port's request is issued to memory.
- A *_request arriving while the same port is pending or in flight is a protocol violation and is ignored.

**State machine: IDLE, BUSY_D, BUSY_I**
- Arbitration point: IDLE, or the cycle in which the current transaction ends (mem_ack or timeout).
- Candidates at the arbitration point: pending flags OR'd with same-cycle *_request inputs.
- Only one candidate: grant it. Both candidates: grant the port opposite to last_grant.
- On a grant, mem_request pulses on the next cycle, last_grant is updated, and the state moves to BUSY_D or BUSY_I.

**Fetch encoding**
- Instruction fetches drive mem_write=0, mem_byte_enable=4'hF, mem_wdata=0.

**Completion**
- BUSY_x with mem_ack high: on the next cycle, cpux_ack pulses and cpux_rdata = the captured mem_rdata. This applies to writes as well; rdata for writes is don't-care.

**Timeout**
- A counter of width $clog2(TIMEOUT_CYCLES+1) clears on the mem_request cycle and increments on each BUSY cycle without mem_ack.
- If the counter equals TIMEOUT_CYCLES with no mem_ack, the transaction aborts.
- Abort response, on the next cycle: cpux_ack=1, cpux_rdata=32'hDEADBEEF, bus_error=1.

**Ignored acks**
- mem_ack in IDLE is ignored: no ack is produced and no state changes. This covers the late ack of an aborted transaction.

**Reset**
- reset low clears all outputs, pending flags, counter and state; state goes to IDLE and last_grant = I, so data wins the first tie.
- A transaction in flight at reset is dropped; its later mem_ack is ignored.

## Timing
**Reset values**
- mem_request, mem_write, cpud_ack, cpui_ack, bus_error: 0.
- mem_addr, mem_byte_enable, mem_wdata, cpud_rdata, cpui_rdata: 0.

**Latency**
- Request at cycle N in IDLE: mem_request at N+1.
- Earliest mem_ack at N+2; CPU ack one cycle after mem_ack. Minimum round trip is 3 cycles.

**Back-to-back**
- The next grant's mem_request coincides with the previous port's CPU ack, with no idle cycle.

**Simultaneous events**
- cpud_request and cpui_request in the same cycle: both are captured and granted round-robin.
- A *_request on the completing port in its own ack cycle is legal and is captured.

**Timeout**
- A transaction that never sees mem_ack produces its CPU ack TIMEOUT_CYCLES+1 cycles after mem_request.

**Outputs**
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Single read:** reset released; cpud_request, addr 0x1000, read at cycle 0; mem_ack with rdata 0x12345678 at cycle 2 → mem_request/mem_addr=0x1000 at cycle 1, cpud_ack with cpud_rdata=0x12345678 at cycle 3, cpui_ack stays 0.
- **Simultaneous requests:** cpud (write 0x2000, be 4'b0011, wdata 0xAABBCCDD) and cpui (0x0100) at cycle 0 after reset → data issued first with mem_write=1, be 0011; fetch issued on the cycle cpud_ack pulses with be=F, write=0; cpui_ack follows.
- **Round-robin:** keep both ports requesting again on each ack for 6 transactions → grant order D,I,D,I,D,I.
- **Timeout:** TIMEOUT_CYCLES=4, fetch at 0x40, mem_ack never asserted → cpui_ack, cpui_rdata=0xDEADBEEF and bus_error at mem_request+5; a late mem_ack in IDLE produces no ack.
- **Reset mid-transaction:** reset low while BUSY_D, then high; mem_ack arrives afterwards → no cpud_ack, all outputs 0; a subsequent fetch completes normally.
- **Protocol violation:** a second cpud_request while the data port is in flight → ignored; exactly one mem_request and one cpud_ack.

Source files
------------

// File: rtl/cpu_bus_arbiter.sv
// Merges the CPU instruction and data ports onto one pulse-request/ack memory bus.
// One transaction in flight at a time, round-robin on ties, error response on memory timeout.
module cpu_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpud_request,
   input  logic [31:0] cpud_addr,
   input  logic        cpud_write,
   input  logic [3:0]  cpud_byte_enable,
   input  logic [31:0] cpud_wdata,
   output logic [31:0] cpud_rdata,
   output logic        cpud_ack,
   input  logic        cpui_request,
   input  logic [31:0] cpui_addr,
   output logic [31:0] cpui_rdata,
   output logic        cpui_ack,
   output logic        mem_request,
   output logic [31:0] mem_addr,
   output logic        mem_write,
   output logic [3:0]  mem_byte_enable,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        bus_error
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_e;

   state_e        state_q, state_d;
   logic          pendD_q, pendD_d, pendI_q, pendI_d;
   logic [31:0]   capDAddr_q, capDAddr_d, capDWdata_q, capDWdata_d, capIAddr_q, capIAddr_d;
   logic          capDWrite_q, capDWrite_d;
   logic [3:0]    capDBe_q, capDBe_d;
   logic          lastGrantI_q, lastGrantI_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          memReq_q, memReq_d, memWrite_q, memWrite_d;
   logic [31:0]   memAddr_q, memAddr_d, memWdata_q, memWdata_d;
   logic [3:0]    memBe_q, memBe_d;
   logic          dAck_q, dAck_d, iAck_q, iAck_d, busErr_q, busErr_d;
   logic [31:0]   dRdata_q, dRdata_d, iRdata_q, iRdata_d;

   logic          busy, timeoutHit, txEnd, arbPoint;
   logic          newD, newI, candD, candI, grantD, grantI;

   always_comb begin
      busy       = (state_q != IDLE);
      timeoutHit = busy && !mem_ack && (cnt_q == TMAX);
      txEnd      = busy && (mem_ack || timeoutHit);
      arbPoint   = !busy || txEnd;

      // A port whose request is still pending or on the bus cannot take another one.
      newD   = cpud_request && !pendD_q && !(state_q == BUSY_D && !txEnd);
      newI   = cpui_request && !pendI_q && !(state_q == BUSY_I && !txEnd);
      candD  = pendD_q || newD;
      candI  = pendI_q || newI;
      grantD = arbPoint && candD && (!candI || lastGrantI_q);
      grantI = arbPoint && candI && !grantD;

      pendD_d     = grantD ? 1'b0 : (pendD_q || newD);
      pendI_d     = grantI ? 1'b0 : (pendI_q || newI);
      capDAddr_d  = newD ? cpud_addr        : capDAddr_q;
      capDWrite_d = newD ? cpud_write       : capDWrite_q;
      capDBe_d    = newD ? cpud_byte_enable : capDBe_q;
      capDWdata_d = newD ? cpud_wdata       : capDWdata_q;
      capIAddr_d  = newI ? cpui_addr        : capIAddr_q;

      lastGrantI_d = lastGrantI_q;
      state_d      = state_q;
      cnt_d        = cnt_q;
      memReq_d     = grantD || grantI;
      memAddr_d    = memAddr_q;
      memWrite_d   = memWrite_q;
      memBe_d      = memBe_q;
      memWdata_d   = memWdata_q;

      if (grantD) begin
         state_d      = BUSY_D;
         lastGrantI_d = 1'b0;
         cnt_d        = '0;
         memAddr_d    = pendD_q ? capDAddr_q  : cpud_addr;
         memWrite_d   = pendD_q ? capDWrite_q : cpud_write;
         memBe_d      = pendD_q ? capDBe_q    : cpud_byte_enable;
         memWdata_d   = pendD_q ? capDWdata_q : cpud_wdata;
      end else if (grantI) begin
         state_d      = BUSY_I;
         lastGrantI_d = 1'b1;
         cnt_d        = '0;
         memAddr_d    = pendI_q ? capIAddr_q : cpui_addr;
         memWrite_d   = 1'b0;
         memBe_d      = 4'hF;
         memWdata_d   = '0;
      end else if (txEnd) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (busy) begin
         cnt_d = cnt_q + CW'(1);
      end

      // Completion response: an aborted transaction returns a marker word and flags the error.
      dAck_d   = (state_q == BUSY_D) && txEnd;
      iAck_d   = (state_q == BUSY_I) && txEnd;
      busErr_d = timeoutHit;
      dRdata_d = dAck_d ? (timeoutHit ? 32'hDEADBEEF : mem_rdata) : dRdata_q;
      iRdata_d = iAck_d ? (timeoutHit ? 32'hDEADBEEF : mem_rdata) : iRdata_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         pendD_q      <= 1'b0;
         pendI_q      <= 1'b0;
         capDAddr_q   <= '0;
         capDWrite_q  <= 1'b0;
         capDBe_q     <= '0;
         capDWdata_q  <= '0;
         capIAddr_q   <= '0;
         lastGrantI_q <= 1'b1;
         cnt_q        <= '0;
         memReq_q     <= 1'b0;
         memAddr_q    <= '0;
         memWrite_q   <= 1'b0;
         memBe_q      <= '0;
         memWdata_q   <= '0;
         dAck_q       <= 1'b0;
         iAck_q       <= 1'b0;
         busErr_q     <= 1'b0;
         dRdata_q     <= '0;
         iRdata_q     <= '0;
      end else begin
         state_q      <= state_d;
         pendD_q      <= pendD_d;
         pendI_q      <= pendI_d;
         capDAddr_q   <= capDAddr_d;
         capDWrite_q  <= capDWrite_d;
         capDBe_q     <= capDBe_d;
         capDWdata_q  <= capDWdata_d;
         capIAddr_q   <= capIAddr_d;
         lastGrantI_q <= lastGrantI_d;
         cnt_q        <= cnt_d;
         memReq_q     <= memReq_d;
         memAddr_q    <= memAddr_d;
         memWrite_q   <= memWrite_d;
         memBe_q      <= memBe_d;
         memWdata_q   <= memWdata_d;
         dAck_q       <= dAck_d;
         iAck_q       <= iAck_d;
         busErr_q     <= busErr_d;
         dRdata_q     <= dRdata_d;
         iRdata_q     <= iRdata_d;
      end
   end

   assign mem_request     = memReq_q;
   assign mem_addr        = memAddr_q;
   assign mem_write       = memWrite_q;
   assign mem_byte_enable = memBe_q;
   assign mem_wdata       = memWdata_q;
   assign cpud_ack        = dAck_q;
   assign cpud_rdata      = dRdata_q;
   assign cpui_ack        = iAck_q;
   assign cpui_rdata      = iRdata_q;
   assign bus_error       = busErr_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: single read, tie-break, round-robin, timeout,
// reset mid-transaction and ignored protocol violations.
module tb_cpu_bus_arbiter;

   logic        clock;
   logic        reset;
   logic        cpud_request, cpud_write;
   logic [31:0] cpud_addr, cpud_wdata, cpud_rdata;
   logic [3:0]  cpud_byte_enable;
   logic        cpud_ack;
   logic        cpui_request;
   logic [31:0] cpui_addr, cpui_rdata;
   logic        cpui_ack;
   logic        mem_request, mem_write, mem_ack, bus_error;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_byte_enable;

   int assertCount = 0;
   int failCount   = 0;

   cpu_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clock(clock), .reset(reset),
      .cpud_request(cpud_request), .cpud_addr(cpud_addr), .cpud_write(cpud_write),
      .cpud_byte_enable(cpud_byte_enable), .cpud_wdata(cpud_wdata),
      .cpud_rdata(cpud_rdata), .cpud_ack(cpud_ack),
      .cpui_request(cpui_request), .cpui_addr(cpui_addr),
      .cpui_rdata(cpui_rdata), .cpui_ack(cpui_ack),
      .mem_request(mem_request), .mem_addr(mem_addr), .mem_write(mem_write),
      .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_error(bus_error)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   task automatic nextCycle();
      @(negedge clock);
   endtask

   task automatic applyStimulus(input logic dReq, input logic [31:0] dAddr, input logic dWr,
                                input logic [3:0] dBe, input logic [31:0] dWdata,
                                input logic iReq, input logic [31:0] iAddr);
      cpud_request     = dReq;
      cpud_addr        = dAddr;
      cpud_write       = dWr;
      cpud_byte_enable = dBe;
      cpud_wdata       = dWdata;
      cpui_request     = iReq;
      cpui_addr        = iAddr;
   endtask

   task automatic idleInputs();
      applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
   endtask

   task automatic doReset();
      reset = 1'b0;
      idleInputs();
      nextCycle();
      nextCycle();
      reset = 1'b1;
   endtask

   initial begin
      int expI, waitCnt, mReqs, dAcks;
      reset = 1'b0;
      idleInputs();
      nextCycle();
      nextCycle();

      // Reset values
      checkOutput("rst_mem_request", 32'(mem_request), 32'd0);
      checkOutput("rst_mem_write", 32'(mem_write), 32'd0);
      checkOutput("rst_mem_addr", mem_addr, 32'd0);
      checkOutput("rst_mem_be", 32'(mem_byte_enable), 32'd0);
      checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
      checkOutput("rst_cpud_ack", 32'(cpud_ack), 32'd0);
      checkOutput("rst_cpui_ack", 32'(cpui_ack), 32'd0);
      checkOutput("rst_cpud_rdata", cpud_rdata, 32'd0);
      checkOutput("rst_cpui_rdata", cpui_rdata, 32'd0);
      checkOutput("rst_bus_error", 32'(bus_error), 32'd0);

      // Single read
      doReset();
      applyStimulus(1'b1, 32'h1000, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0);
      nextCycle();
      idleInputs();
      checkOutput("rd_mem_request", 32'(mem_request), 32'd1);
      checkOutput("rd_mem_addr", mem_addr, 32'h1000);
      checkOutput("rd_mem_write", 32'(mem_write), 32'd0);
      nextCycle();
      checkOutput("rd_mem_request_pulse", 32'(mem_request), 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'h12345678;
      nextCycle();
      mem_ack = 1'b0; mem_rdata = 32'h0;
      checkOutput("rd_cpud_ack", 32'(cpud_ack), 32'd1);
      checkOutput("rd_cpud_rdata", cpud_rdata, 32'h12345678);
      checkOutput("rd_cpui_ack", 32'(cpui_ack), 32'd0);
      checkOutput("rd_bus_error", 32'(bus_error), 32'd0);
      nextCycle();
      checkOutput("rd_cpud_ack_pulse", 32'(cpud_ack), 32'd0);
      checkOutput("rd_cpud_rdata_held", cpud_rdata, 32'h12345678);

      // Simultaneous requests: data wins the first tie
      doReset();
      applyStimulus(1'b1, 32'h2000, 1'b1, 4'b0011, 32'hAABBCCDD, 1'b1, 32'h0100);
      nextCycle();
      idleInputs();
      checkOutput("sim_d_mem_request", 32'(mem_request), 32'd1);
      checkOutput("sim_d_mem_addr", mem_addr, 32'h2000);
      checkOutput("sim_d_mem_write", 32'(mem_write), 32'd1);
      checkOutput("sim_d_mem_be", 32'(mem_byte_enable), 32'h3);
      checkOutput("sim_d_mem_wdata", mem_wdata, 32'hAABBCCDD);
      nextCycle();
      mem_ack = 1'b1; mem_rdata = 32'h0;
      nextCycle();
      mem_ack = 1'b0;
      checkOutput("sim_cpud_ack", 32'(cpud_ack), 32'd1);
      checkOutput("sim_i_mem_request", 32'(mem_request), 32'd1);
      checkOutput("sim_i_mem_addr", mem_addr, 32'h0100);
      checkOutput("sim_i_mem_write", 32'(mem_write), 32'd0);
      checkOutput("sim_i_mem_be", 32'(mem_byte_enable), 32'hF);
      checkOutput("sim_i_mem_wdata", mem_wdata, 32'h0);
      nextCycle();
      mem_ack = 1'b1; mem_rdata = 32'h13579BDF;
      nextCycle();
      mem_ack = 1'b0; mem_rdata = 32'h0;
      checkOutput("sim_cpui_ack", 32'(cpui_ack), 32'd1);
      checkOutput("sim_cpui_rdata", cpui_rdata, 32'h13579BDF);
      checkOutput("sim_cpud_ack_low", 32'(cpud_ack), 32'd0);

      // Round-robin over six transactions: D,I,D,I,D,I
      doReset();
      applyStimulus(1'b1, 32'h3000, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0200);
      nextCycle();
      idleInputs();
      for (int t = 0; t < 6; t++) begin
         expI = t % 2;
         waitCnt = 0;
         while (!mem_request && waitCnt < 10) begin
            nextCycle();
            waitCnt++;
         end
         checkOutput($sformatf("rr%0d_issued", t), 32'(waitCnt < 10), 32'd1);
         checkOutput($sformatf("rr%0d_addr", t), mem_addr, (expI != 0) ? 32'h0200 : 32'h3000);
         nextCycle();
         idleInputs();
         mem_ack = 1'b1; mem_rdata = 32'h100 + 32'(t);
         nextCycle();
         mem_ack = 1'b0; mem_rdata = 32'h0;
         checkOutput($sformatf("rr%0d_cpud_ack", t), 32'(cpud_ack), (expI == 0) ? 32'd1 : 32'd0);
         checkOutput($sformatf("rr%0d_cpui_ack", t), 32'(cpui_ack), (expI != 0) ? 32'd1 : 32'd0);
         if (t < 4) begin
            if (expI != 0) applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0200);
            else           applyStimulus(1'b1, 32'h3000, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0);
         end
      end
      nextCycle();
      idleInputs();

      // Timeout with TIMEOUT_CYCLES=4: abort response five cycles after mem_request
      doReset();
      applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h40);
      nextCycle();
      idleInputs();
      checkOutput("to_mem_request", 32'(mem_request), 32'd1);
      checkOutput("to_mem_addr", mem_addr, 32'h40);
      for (int k = 1; k <= 4; k++) begin
         nextCycle();
         checkOutput($sformatf("to_no_ack_%0d", k), 32'(cpui_ack), 32'd0);
      end
      nextCycle();
      checkOutput("to_cpui_ack", 32'(cpui_ack), 32'd1);
      checkOutput("to_cpui_rdata", cpui_rdata, 32'hDEADBEEF);
      checkOutput("to_bus_error", 32'(bus_error), 32'd1);
      nextCycle();
      checkOutput("to_bus_error_pulse", 32'(bus_error), 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'h55555555;
      nextCycle();
      mem_ack = 1'b0; mem_rdata = 32'h0;
      checkOutput("late_cpui_ack", 32'(cpui_ack), 32'd0);
      checkOutput("late_cpud_ack", 32'(cpud_ack), 32'd0);
      checkOutput("late_mem_request", 32'(mem_request), 32'd0);
      checkOutput("late_cpui_rdata", cpui_rdata, 32'hDEADBEEF);

      // Reset in the middle of a data transaction
      doReset();
      applyStimulus(1'b1, 32'h5000, 1'b1, 4'hF, 32'h11, 1'b0, 32'h0);
      nextCycle();
      idleInputs();
      checkOutput("mr_mem_request", 32'(mem_request), 32'd1);
      nextCycle();
      reset = 1'b0;
      nextCycle();
      reset = 1'b1;
      checkOutput("mr_mem_addr_cleared", mem_addr, 32'h0);
      checkOutput("mr_mem_write_cleared", 32'(mem_write), 32'd0);
      nextCycle();
      mem_ack = 1'b1; mem_rdata = 32'h77777777;
      nextCycle();
      mem_ack = 1'b0; mem_rdata = 32'h0;
      checkOutput("mr_no_cpud_ack", 32'(cpud_ack), 32'd0);
      checkOutput("mr_cpud_rdata", cpud_rdata, 32'h0);
      checkOutput("mr_mem_request", 32'(mem_request), 32'd0);
      checkOutput("mr_mem_wdata", mem_wdata, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h80);
      nextCycle();
      idleInputs();
      checkOutput("mr_fetch_request", 32'(mem_request), 32'd1);
      checkOutput("mr_fetch_addr", mem_addr, 32'h80);
      nextCycle();
      mem_ack = 1'b1; mem_rdata = 32'h0000CAFE;
      nextCycle();
      mem_ack = 1'b0; mem_rdata = 32'h0;
      checkOutput("mr_fetch_ack", 32'(cpui_ack), 32'd1);
      checkOutput("mr_fetch_rdata", cpui_rdata, 32'h0000CAFE);

      // Second data request while the first is in flight is dropped
      doReset();
      applyStimulus(1'b1, 32'h6000, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0);
      nextCycle();
      mReqs = 0;
      dAcks = 0;
      for (int c = 0; c < 10; c++) begin
         if (mem_request) mReqs++;
         if (cpud_ack) dAcks++;
         if (c == 0) begin
            checkOutput("pv_mem_addr", mem_addr, 32'h6000);
            applyStimulus(1'b1, 32'h7000, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0);
         end else if (c == 1) begin
            idleInputs();
            mem_ack = 1'b1; mem_rdata = 32'h66;
         end else begin
            idleInputs();
         end
         nextCycle();
      end
      checkOutput("pv_mem_request_count", 32'(mReqs), 32'd1);
      checkOutput("pv_cpud_ack_count", 32'(dAcks), 32'd1);
      checkOutput("pv_cpud_rdata", cpud_rdata, 32'h66);
      checkOutput("pv_mem_addr_final", mem_addr, 32'h6000);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
